alu_register_unit: RTL and testbench
====================================

Name: alu_register_unit

Overview:
- Datapath slice for the picoComputer CPU with two independent parts sharing one module boundary.
- Part 1 is a purely combinational N-bit ALU selected by a 3-bit opcode.
- Part 2 is a clocked N-bit general-purpose register with clear, parallel load, increment/decrement and serial-in shift left/right.
- The ALU and register are not internally connected; the surrounding CPU wires them together.

Parameters:
- WIDTH, 4, data width of ALU operands/result and of the register.

Ports:
- clk  input  1  single clock; all register state changes on its rising edge.
- rst_n  input  1  synchronous reset, active-high despite the _n suffix; sampled on the rising edge of clk.
- oc  input  3  ALU opcode.
- a  input  WIDTH  ALU operand A.
- b  input  WIDTH  ALU operand B.
- f  output  WIDTH  ALU result, combinational.
- cl  input  1  register clear.
- ld  input  1  register parallel load.
- in  input  WIDTH  register load data.
- inc  input  1  register increment.
- dec  input  1  register decrement.
- sr  input  1  register shift right.
- ir  input  1  serial bit shifted into the MSB on shift right.
- sl  input  1  register shift left.
- il  input  1  serial bit shifted into the LSB on shift left.
- out  output  WIDTH  register contents.

Behaviour:
- ALU is combinational with zero latency; f follows oc/a/b changes in the same delta.
- All ALU arithmetic is unsigned and truncated to WIDTH bits (modulo 2^WIDTH); there is no carry or flag output.
- oc=000: f = a + b.
- oc=001: f = a - b (wraps, e.g. 2-5 = 13).
- oc=010: f = low WIDTH bits of a * b.
- oc=011: f = a / b (integer quotient); if b=0 then f=0.
- oc=100: f = ~a (b ignored).
- oc=101: f = a ^ b.
- oc=110: f = a | b.
- oc=111: f = a & b.
- Register is updated only on the rising edge of clk; out is the register value directly (no extra output stage).
- Per-edge priority, first match wins:
  1. rst_n=1: out <= 0.
  2. cl=1: out <= 0.
  3. ld=1: out <= in.
  4. inc=1: out <= out+1, wrapping 15->0.
  5. dec=1: out <= out-1, wrapping 0->15.
  6. sr=1: out <= {ir, out[WIDTH-1:1]}.
  7. sl=1: out <= {out[WIDTH-2:0], il}.
  8. Otherwise: out holds.
- Reset value: out=0. f has no reset and always reflects its inputs.
- Simultaneous controls are resolved strictly by the priority above; lower-priority controls are ignored that cycle (e.g. inc=dec=1 increments; sr=sl=1 shifts right).
- ir is only used when sr is the winning operation; il is only used when sl is the winning operation.
- Control inputs that are X/Z after reset are not required to behave predictably; the bench drives all controls to known values once reset is released.
- Reset asserted mid-operation overrides everything on that edge; the register resumes from 0 on the next edge after release.

Test Plan:
- ALU exhaustive sweep: all 2^11 combinations of {oc,a,b}, each compared against a reference model. Spot checks: oc=000 a=9 b=8 -> f=1; oc=001 a=2 b=5 -> f=13; oc=010 a=5 b=7 -> f=3; oc=011 a=13 b=4 -> f=3; oc=011 b=0 -> f=0; oc=100 a=5 -> f=10.
- Reset: rst_n=1 for 2 edges with ld=1 in=9 -> out=0. Release rst_n, then ld=1 in=9 for one edge -> out=9.
- Counting wrap: load 15, then inc=1 -> 0. Load 0, then dec=1 -> 15. Load 6 with inc=dec=1 -> 7.
- Shifts: load 4'b1001. sr=1 ir=1 -> 1100. Then sl=1 il=0 -> 1000. Then sl=1 il=1 -> 0001.
- Priority: out=5 with cl=ld=inc=1 -> 0. Then ld=1 in=10 with inc=sr=1 -> 10. Then all controls 0 -> holds 10.
- Randomized: 1000 cycles of random cl/ld/in/inc/dec/sr/ir/sl/il, with out compared each edge against a priority model.

Source files
------------

// File: rtl/alu_register_unit.sv
// alu_register_unit: datapath slice for the picoComputer CPU.
// Holds two independent parts: a combinational WIDTH-bit ALU and a clocked
// WIDTH-bit general-purpose register. They share no internal wiring.
//
// Ports:
//   clk    - clock; register state changes on its rising edge
//   rst_n  - synchronous reset, active-high (historical name)
//   oc     - ALU opcode (3 bits)
//   a, b   - ALU operands
//   f      - ALU result, combinational
//   cl     - register clear
//   ld     - register parallel load from 'in'
//   in     - register load data
//   inc    - register increment (wraps)
//   dec    - register decrement (wraps)
//   sr, ir - shift right, serial bit entering the MSB
//   sl, il - shift left, serial bit entering the LSB
//   out    - register contents
module alu_register_unit #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       oc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] f,
   input  logic             cl,
   input  logic             ld,
   input  logic [WIDTH-1:0] in,
   input  logic             inc,
   input  logic             dec,
   input  logic             sr,
   input  logic             ir,
   input  logic             sl,
   input  logic             il,
   output logic [WIDTH-1:0] out
);

   localparam logic [2:0] OC_ADD = 3'b000;
   localparam logic [2:0] OC_SUB = 3'b001;
   localparam logic [2:0] OC_MUL = 3'b010;
   localparam logic [2:0] OC_DIV = 3'b011;
   localparam logic [2:0] OC_NOT = 3'b100;
   localparam logic [2:0] OC_XOR = 3'b101;
   localparam logic [2:0] OC_OR  = 3'b110;
   localparam logic [2:0] OC_AND = 3'b111;

   logic [WIDTH-1:0] reg_q;
   logic [WIDTH-1:0] reg_d;

   // ALU: unsigned, results truncated to WIDTH bits, no flags.
   always_comb begin
      f = '0;
      case (oc)
         OC_ADD:  f = a + b;
         OC_SUB:  f = a - b;
         OC_MUL:  f = a * b;
         // Divide by zero yields zero rather than X.
         OC_DIV:  f = (b == '0) ? '0 : a / b;
         OC_NOT:  f = ~a;
         OC_XOR:  f = a ^ b;
         OC_OR:   f = a | b;
         OC_AND:  f = a & b;
         default: f = '0;
      endcase
   end

   // Register next value: fixed priority, first active control wins.
   always_comb begin
      reg_d = reg_q;
      if (cl) begin
         reg_d = '0;
      end else if (ld) begin
         reg_d = in;
      end else if (inc) begin
         reg_d = reg_q + WIDTH'(1);
      end else if (dec) begin
         reg_d = reg_q - WIDTH'(1);
      end else if (sr) begin
         reg_d = {ir, reg_q[WIDTH-1:1]};
      end else if (sl) begin
         reg_d = {reg_q[WIDTH-2:0], il};
      end
   end

   // State register; reset overrides every control on the same edge.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         reg_q <= '0;
      end else begin
         reg_q <= reg_d;
      end
   end

   assign out = reg_q;

endmodule

// File: tb/tb_alu_register_unit.sv
// Directed bench for alu_register_unit: exhaustive ALU sweep against an
// integer reference, directed register scenarios, and a random run checked
// against a priority model of the register.
module tb_alu_register_unit;

   localparam int unsigned W    = 4;
   localparam int          MASK = (1 << W) - 1;

   logic         clk;
   logic         rst_n;
   logic [2:0]   oc;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] f;
   logic         cl;
   logic         ld;
   logic [W-1:0] in;
   logic         inc;
   logic         dec;
   logic         sr;
   logic         ir;
   logic         sl;
   logic         il;
   logic [W-1:0] out;

   int errors = 0;
   int checks = 0;

   alu_register_unit #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .oc   (oc),
      .a    (a),
      .b    (b),
      .f    (f),
      .cl   (cl),
      .ld   (ld),
      .in   (in),
      .inc  (inc),
      .dec  (dec),
      .sr   (sr),
      .ir   (ir),
      .sl   (sl),
      .il   (il),
      .out  (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs,
                        input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference ALU in plain integer arithmetic.
   function automatic logic [W-1:0] alu_ref(input int op, input int x, input int y);
      int r;
      case (op)
         0:       r = x + y;
         1:       r = x - y + (1 << W);
         2:       r = x * y;
         3:       r = (y == 0) ? 0 : x / y;
         4:       r = MASK - x;
         5:       r = x ^ y;
         6:       r = x | y;
         default: r = x & y;
      endcase
      return W'(r & MASK);
   endfunction

   // Reference register update, first active control wins.
   function automatic logic [W-1:0] reg_ref(input int m, input bit c_cl, input bit c_ld,
                                            input int d, input bit c_inc, input bit c_dec,
                                            input bit c_sr, input bit c_ir,
                                            input bit c_sl, input bit c_il);
      int r;
      if (c_cl)       r = 0;
      else if (c_ld)  r = d;
      else if (c_inc) r = (m + 1) % (1 << W);
      else if (c_dec) r = (m + MASK) % (1 << W);
      else if (c_sr)  r = (int'(c_ir) << (W - 1)) | (m >> 1);
      else if (c_sl)  r = ((m << 1) & MASK) | int'(c_il);
      else            r = m;
      return W'(r & MASK);
   endfunction

   task automatic set_ctl(input bit c_cl, input bit c_ld, input logic [W-1:0] d,
                          input bit c_inc, input bit c_dec, input bit c_sr,
                          input bit c_ir, input bit c_sl, input bit c_il);
      cl = c_cl; ld = c_ld; in = d; inc = c_inc; dec = c_dec;
      sr = c_sr; ir = c_ir; sl = c_sl; il = c_il;
   endtask

   // One rising edge, then settle away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_spot(input string tag, input logic [2:0] op,
                           input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] exp);
      oc = op; a = x; b = y;
      #1;
      check(tag, f, exp);
   endtask

   initial begin
      logic [W-1:0] model;
      bit r_cl, r_ld, r_inc, r_dec, r_sr, r_ir, r_sl, r_il;
      logic [W-1:0] r_in;

      rst_n = 1'b1;
      oc = 3'b000; a = '0; b = '0;
      set_ctl(0, 1, 4'd9, 0, 0, 0, 0, 0, 0);

      // ALU spot checks
      alu_spot("alu_add_wrap", 3'b000, 4'd9,  4'd8, 4'd1);
      alu_spot("alu_sub_wrap", 3'b001, 4'd2,  4'd5, 4'd13);
      alu_spot("alu_mul_trunc", 3'b010, 4'd5, 4'd7, 4'd3);
      alu_spot("alu_div",      3'b011, 4'd13, 4'd4, 4'd3);
      alu_spot("alu_div_zero", 3'b011, 4'd13, 4'd0, 4'd0);
      alu_spot("alu_not",      3'b100, 4'd5,  4'd3, 4'd10);
      alu_spot("alu_xor",      3'b101, 4'd12, 4'd10, 4'd6);
      alu_spot("alu_or",       3'b110, 4'd12, 4'd10, 4'd14);
      alu_spot("alu_and",      3'b111, 4'd12, 4'd10, 4'd8);

      // ALU exhaustive sweep
      for (int op = 0; op < 8; op++) begin
         for (int x = 0; x < (1 << W); x++) begin
            for (int y = 0; y < (1 << W); y++) begin
               oc = 3'(op); a = W'(x); b = W'(y);
               #1;
               check($sformatf("alu_sweep oc=%0d a=%0d b=%0d", op, x, y),
                     f, alu_ref(op, x, y));
            end
         end
      end

      // Reset held for two edges with a load pending
      tick();
      tick();
      check("reset_overrides_load", out, 4'd0);
      rst_n = 1'b0;
      tick();
      check("load_after_reset", out, 4'd9);

      // Counter wrap
      set_ctl(0, 1, 4'd15, 0, 0, 0, 0, 0, 0); tick();
      set_ctl(0, 0, 4'd0, 1, 0, 0, 0, 0, 0);  tick();
      check("inc_wrap", out, 4'd0);
      set_ctl(0, 1, 4'd0, 0, 0, 0, 0, 0, 0);  tick();
      set_ctl(0, 0, 4'd0, 0, 1, 0, 0, 0, 0);  tick();
      check("dec_wrap", out, 4'd15);
      set_ctl(0, 1, 4'd6, 0, 0, 0, 0, 0, 0);  tick();
      set_ctl(0, 0, 4'd0, 1, 1, 0, 0, 0, 0);  tick();
      check("inc_beats_dec", out, 4'd7);

      // Shifts
      set_ctl(0, 1, 4'b1001, 0, 0, 0, 0, 0, 0); tick();
      set_ctl(0, 0, 4'd0, 0, 0, 1, 1, 0, 0);    tick();
      check("shift_right_ir1", out, 4'b1100);
      set_ctl(0, 0, 4'd0, 0, 0, 0, 0, 1, 0);    tick();
      check("shift_left_il0", out, 4'b1000);
      set_ctl(0, 0, 4'd0, 0, 0, 0, 0, 1, 1);    tick();
      check("shift_left_il1", out, 4'b0001);
      set_ctl(0, 0, 4'd0, 0, 0, 1, 0, 1, 1);    tick();
      check("sr_beats_sl", out, 4'b0000);

      // Priority
      set_ctl(0, 1, 4'd5, 0, 0, 0, 0, 0, 0);    tick();
      set_ctl(1, 1, 4'd9, 1, 0, 0, 0, 0, 0);    tick();
      check("clear_beats_all", out, 4'd0);
      set_ctl(0, 1, 4'd10, 1, 0, 1, 1, 0, 0);   tick();
      check("load_beats_inc_sr", out, 4'd10);
      set_ctl(0, 0, 4'd3, 0, 0, 0, 1, 0, 1);    tick();
      check("hold", out, 4'd10);

      // Reset mid-operation, then resume from zero
      rst_n = 1'b1;
      set_ctl(0, 0, 4'd0, 1, 0, 0, 0, 0, 0);    tick();
      check("reset_mid_op", out, 4'd0);
      rst_n = 1'b0;
      tick();
      check("resume_after_reset", out, 4'd1);

      // Random run against the priority model
      model = out;
      for (int i = 0; i < 1000; i++) begin
         r_cl  = ($urandom_range(0, 15) == 0);
         r_ld  = ($urandom_range(0, 7) == 0);
         r_in  = W'($urandom_range(0, MASK));
         r_inc = ($urandom_range(0, 3) == 0);
         r_dec = ($urandom_range(0, 3) == 0);
         r_sr  = 1'($urandom_range(0, 1));
         r_ir  = 1'($urandom_range(0, 1));
         r_sl  = 1'($urandom_range(0, 1));
         r_il  = 1'($urandom_range(0, 1));
         set_ctl(r_cl, r_ld, r_in, r_inc, r_dec, r_sr, r_ir, r_sl, r_il);
         model = reg_ref(int'(model), r_cl, r_ld, int'(r_in), r_inc, r_dec,
                         r_sr, r_ir, r_sl, r_il);
         tick();
         check($sformatf("random cycle %0d", i), out, model);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
